// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: decoder MdOp values and FSM states.
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } mdOp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } mdState_t;

endpackage

// File: rtl/md_iter_core.sv
// One combinational iteration of the multiply/divide datapath over a 2*WIDTH accumulator.
module md_iter_core #(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic               isDiv,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] accNext
);

  localparam int W2 = 2 * WIDTH;

  logic [WIDTH:0]   mulSum;
  logic [W2-1:0]    fastProd;
  logic [W2:0]      divShift;
  logic [WIDTH:0]   divTrial;

  always_comb begin
    // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, then shift right.
    mulSum   = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    fastProd = W2'(operand) * W2'(acc[WIDTH-1:0]);
    // Divide: acc = {remainder, dividend}; shift left, keep the trial subtraction if it fits.
    divShift = {acc, 1'b0};
    divTrial = divShift[W2:WIDTH] - {1'b0, operand};
    accNext  = acc;
    if (isDiv) begin
      if (!divTrial[WIDTH]) accNext = {divTrial[WIDTH-1:0], divShift[WIDTH-1:1], 1'b1};
      else                  accNext = divShift[W2-1:0];
    end else begin
      accNext = FAST_MUL ? fastProd : {mulSum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers, busy/done handshake and flush.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hilo_write,
  input  logic             hilo_sel,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output mdState_t         dbgState
);

  localparam int CW = $clog2(WIDTH + 1);

  mdState_t             state, stateNext;
  logic [CW-1:0]        counter;
  logic                 isDivReg, signA, signB;
  logic [WIDTH-1:0]     operand, rawA;
  logic [2*WIDTH-1:0]   acc, accNext, prodFix;
  logic                 aNeg, bNeg;
  logic [WIDTH-1:0]     absA, absB, fixHi, fixLo;

  md_iter_core #(.WIDTH(WIDTH), .FAST_MUL(FAST_MUL)) uCore (
    .isDiv   (isDivReg),
    .acc     (acc),
    .operand (operand),
    .accNext (accNext)
  );

  assign aNeg     = md_op[0] & src_a[WIDTH-1];
  assign bNeg     = md_op[0] & src_b[WIDTH-1];
  assign absA     = aNeg ? -src_a : src_a;
  assign absB     = bNeg ? -src_b : src_b;
  assign busy     = (state != ST_IDLE);
  assign dbgState = state;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: if (start && !flush) stateNext = ST_RUN;
      ST_RUN: begin
        if (flush)                   stateNext = ST_IDLE;
        else if (counter == CW'(1))  stateNext = ST_FIX;
      end
      ST_FIX:  stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  // Sign correction; divide by zero returns all-ones quotient and the raw dividend.
  always_comb begin
    prodFix = (signA ^ signB) ? -acc : acc;
    fixHi   = prodFix[2*WIDTH-1:WIDTH];
    fixLo   = prodFix[WIDTH-1:0];
    if (isDivReg) begin
      if (operand == '0) begin
        fixHi = rawA;
        fixLo = '1;
      end else begin
        fixHi = signA ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        fixLo = (signA ^ signB) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter  <= '0;
      isDivReg <= 1'b0;
      signA    <= 1'b0;
      signB    <= 1'b0;
      operand  <= '0;
      rawA     <= '0;
      acc      <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !flush) begin
            isDivReg <= md_op[1];
            signA    <= aNeg;
            signB    <= bNeg;
            rawA     <= src_a;
            operand  <= md_op[1] ? absB : absA;
            acc      <= {{WIDTH{1'b0}}, (md_op[1] ? absA : absB)};
            counter  <= (FAST_MUL && !md_op[1]) ? CW'(1) : CW'(WIDTH);
          end else if (hilo_write && !start) begin
            if (hilo_sel) hi <= src_a;
            else          lo <= src_a;
          end
        end
        ST_RUN: begin
          if (!flush) begin
            acc     <= accNext;
            counter <= counter - CW'(1);
          end
        end
        ST_FIX: begin
          if (!flush) begin
            hi   <= fixHi;
            lo   <= fixLo;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: iterative and single-cycle-multiply instances driven in parallel.
module tb_md_unit;
  import md_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset, start, hilo_write, hilo_sel, flush;
  logic [1:0] md_op;
  logic [W-1:0] src_a, src_b;
  logic busy0, done0, busy1, done1;
  logic [W-1:0] hi0, lo0, hi1, lo1;
  mdState_t st0, st1;

  int checks = 0;
  int errors = 0;
  bit chkEn = 1'b0;
  int n;

  int remC[2];
  logic [W-1:0] mHi[2], mLo[2], pHi[2], pLo[2];
  bit mDone[2];

  always #5 clk = ~clk;

  md_unit #(.WIDTH(W), .FAST_MUL(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .src_a(src_a), .src_b(src_b),
    .hilo_write(hilo_write), .hilo_sel(hilo_sel), .flush(flush),
    .busy(busy0), .done(done0), .hi(hi0), .lo(lo0), .dbgState(st0)
  );

  md_unit #(.WIDTH(W), .FAST_MUL(1'b1)) dutF (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .src_a(src_a), .src_b(src_b),
    .hilo_write(hilo_write), .hilo_sel(hilo_sel), .flush(flush),
    .busy(busy1), .done(done1), .hi(hi1), .lo(lo1), .dbgState(st1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Architectural result of one operation, from plain signed/unsigned arithmetic.
  function automatic void modelOp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] h, output logic [W-1:0] l);
    longint sa, sb, p;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == MD_MULTU) begin
      u = {32'b0, a} * {32'b0, b};
      h = u[63:32]; l = u[31:0];
    end else if (op == MD_MULT) begin
      p = sa * sb; u = p;
      h = u[63:32]; l = u[31:0];
    end else if (b == '0) begin
      h = a; l = '1;
    end else if (op == MD_DIVU) begin
      l = a / b; h = a % b;
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      l = a; h = '0;
    end else begin
      p = sa / sb; u = p; l = u[31:0];
      p = sa % sb; u = p; h = u[31:0];
    end
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [W-1:0] h, l;
      mDone[i] = 1'b0;
      if (reset) begin
        remC[i] = 0; mHi[i] = '0; mLo[i] = '0;
      end else if (remC[i] > 0) begin
        if (flush) remC[i] = 0;
        else begin
          remC[i]--;
          if (remC[i] == 0) begin
            mHi[i] = pHi[i]; mLo[i] = pLo[i]; mDone[i] = 1'b1;
          end
        end
      end else if (start && !flush) begin
        modelOp(md_op, src_a, src_b, h, l);
        pHi[i] = h; pLo[i] = l;
        remC[i] = (i == 1 && !md_op[1]) ? 2 : W + 1;
      end else if (hilo_write && !start) begin
        if (hilo_sel) mHi[i] = src_a;
        else          mLo[i] = src_a;
      end
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      check("d0_busy", busy0, remC[0] > 0);
      check("d0_state_active", st0 != ST_IDLE, remC[0] > 0);
      check("d0_done", done0, mDone[0]);
      check("d0_hi", hi0, mHi[0]);
      check("d0_lo", lo0, mLo[0]);
      check("d1_busy", busy1, remC[1] > 0);
      check("d1_state_active", st1 != ST_IDLE, remC[1] > 0);
      check("d1_done", done1, mDone[1]);
      check("d1_hi", hi1, mHi[1]);
      check("d1_lo", lo1, mLo[1]);
    end
  end

  task automatic cyc(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic doStart(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    md_op = op; src_a = a; src_b = b; start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic waitIdle();
    for (int k = 0; k < 100 && (busy0 || busy1); k++) cyc(1);
    check("idle_wait", {busy0, busy1}, 2'b00);
  endtask

  task automatic countBusy(input int sel, output int cnt);
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sel == 1 ? busy1 : busy0) cnt++;
      else break;
    end
  endtask

  typedef struct { logic [1:0] op; logic [W-1:0] a; logic [W-1:0] b; } vec_t;
  vec_t vecs[5];

  initial begin
    reset = 1'b1; start = 1'b0; md_op = 2'b00; src_a = '0; src_b = '0;
    hilo_write = 1'b0; hilo_sel = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    chkEn = 1'b1;
    @(negedge clk);
    check("rst_busy", busy0, 1'b0);
    check("rst_done", done0, 1'b0);
    check("rst_hi", hi0, 32'h0);
    check("rst_lo", lo0, 32'h0);
    check("rst_state", st0, ST_IDLE);
    cyc(1);
    reset = 1'b0;

    // MULT -3 x 5: 33 busy cycles, result visible with done at T+34
    doStart(MD_MULT, 32'hFFFFFFFD, 32'h00000005);
    countBusy(0, n);
    check("mult_busy_cycles", n, 33);
    check("mult_done", done0, 1'b1);
    check("mult_hi", hi0, 32'hFFFFFFFF);
    check("mult_lo", lo0, 32'hFFFFFFF1);
    cyc(1);

    // MULTU max x max on both instances; fast one done at T+3
    doStart(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    countBusy(1, n);
    check("fmul_busy_cycles", n, 2);
    check("fmul_done", done1, 1'b1);
    check("fmul_hi", hi1, 32'hFFFFFFFE);
    check("fmul_lo", lo1, 32'h00000001);
    cyc(1);
    waitIdle();
    check("multu_hi", hi0, 32'hFFFFFFFE);
    check("multu_lo", lo0, 32'h00000001);

    doStart(MD_DIV, 32'hFFFFFFF9, 32'h00000002);
    waitIdle();
    check("div_neg_lo", lo0, 32'hFFFFFFFD);
    check("div_neg_hi", hi0, 32'hFFFFFFFF);

    doStart(MD_DIVU, 32'h00000007, 32'h00000000);
    waitIdle();
    check("divu_zero_lo", lo0, 32'hFFFFFFFF);
    check("divu_zero_hi", hi0, 32'h00000007);

    doStart(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    waitIdle();
    check("div_min_lo", lo0, 32'h80000000);
    check("div_min_hi", hi0, 32'h00000000);

    vecs[0] = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE};
    vecs[1] = '{MD_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE};
    vecs[2] = '{MD_MULTU, 32'h00010000, 32'h00010000};
    vecs[3] = '{MD_DIVU,  32'hFFFFFFFF, 32'h00000001};
    vecs[4] = '{MD_DIV,   32'hFFFFFFF9, 32'h00000000};
    foreach (vecs[i]) begin
      doStart(vecs[i].op, vecs[i].a, vecs[i].b);
      waitIdle();
    end
    check("div_sign_mix_lo", lo0, 32'hFFFFFFFF);
    check("div_sign_mix_hi", hi0, 32'hFFFFFFF9);

    // Reset, MTHI, then a DIVU with an MTLO and second start while busy
    reset = 1'b1; cyc(1); reset = 1'b0;
    check("rst2_hi", hi0, 32'h0);
    check("rst2_lo", lo0, 32'h0);
    hilo_write = 1'b1; hilo_sel = 1'b1; src_a = 32'h12345678;
    cyc(1);
    hilo_write = 1'b0;
    check("mthi", hi0, 32'h12345678);
    doStart(MD_DIVU, 32'd100, 32'd7);
    cyc(4);
    hilo_write = 1'b1; hilo_sel = 1'b0; src_a = 32'hDEADBEEF;
    start = 1'b1; md_op = MD_MULTU; src_b = 32'h3;
    cyc(1);
    hilo_write = 1'b0; start = 1'b0;
    check("busy_ignore_lo", lo0, 32'h0);
    waitIdle();
    check("divu_lo", lo0, 32'h0000000E);
    check("divu_hi", hi0, 32'h00000002);

    // Flush mid-run: idle next cycle, results untouched
    doStart(MD_MULT, 32'd6, 32'd7);
    cyc(9);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    check("flush_busy", busy0, 1'b0);
    check("flush_done", done0, 1'b0);
    check("flush_hi", hi0, 32'h00000002);
    check("flush_lo", lo0, 32'h0000000E);

    // Reset mid-operation
    doStart(MD_DIV, 32'd100, 32'd3);
    cyc(4);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("rst_mid_busy", busy0, 1'b0);
    check("rst_mid_hi", hi0, 32'h0);
    check("rst_mid_lo", lo0, 32'h0);
    check("rst_mid_fast_hi", hi1, 32'h0);
    cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits in the EX stage and is driven by the decoder's MdOp, HiLoWrite, HiLo and IsMd signals.
- Generalises the fixed 32-bit MULT/MULTU/DIV/DIVU/MTHI/MTLO support:
  - configurable operand width;
  - selectable iterative or single-cycle multiply;
  - busy/done handshake for the hazard unit;
  - flush/abort.

Parameters:
- WIDTH, 32: operand width and HI/LO register width.
- FAST_MUL, 0: 0 selects a radix-2 iterative multiply (WIDTH iterations); 1 selects a one-cycle multiply iteration.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  launch operation; sampled only in IDLE
- md_op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- src_a  in  WIDTH  multiplicand or dividend (rs)
- src_b  in  WIDTH  multiplier or divisor (rt)
- hilo_write  in  1  MTHI/MTLO write strobe
- hilo_sel  in  1  1 = HI, 0 = LO (for hilo_write)
- flush  in  1  abort the in-flight operation
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse when new HI/LO results first become visible
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0. Reset overrides every other input in the same cycle, including mid-operation.
- FSM states: IDLE, RUN, FIX.
  - IDLE with start=1: latch md_op; latch |src_a| and |src_b| for signed ops (raw values for unsigned); latch both sign bits; load counter=WIDTH (1 when FAST_MUL=1 and the op is a multiply); go to RUN.
  - RUN: one iteration per cycle, counter decrements; at counter==1 go to FIX.
  - FIX: apply sign correction, write hi/lo at the clock edge, go to IDLE. done=1 in the following cycle.
- Latency, with start sampled in cycle T:
  - busy is high from T+1 through T+WIDTH+1.
  - In cycle T+WIDTH+2, busy=0, done=1 and hi/lo hold the new results.
  - FAST_MUL multiply: done at T+3.
- Multiply:
  - Shift-add over a 2·WIDTH accumulator.
  - hi = upper WIDTH bits, lo = lower WIDTH bits.
  - MULT: negate the 2·WIDTH product if the operand signs differ.
- Divide:
  - Restoring divide; lo = quotient, hi = remainder.
  - DIV: quotient is negated if signs differ; remainder takes the dividend's sign.
  - Divide by zero (both DIV and DIVU): lo = all ones, hi = src_a. No exception.
  - DIV of MIN by -1: lo = MIN, hi = 0.
- hilo_write:
  - Accepted only in IDLE with start=0; the register is updated at the next edge.
  - Ignored while busy. The hazard unit must stall MTHI/MTLO/MFHI/MFLO while busy=1.
- Simultaneous start and hilo_write in IDLE: start wins and the write is dropped.
- start while busy: ignored, and no queuing.
- flush:
  - In RUN or FIX: return to IDLE next cycle; hi/lo unchanged; no done pulse.
  - In IDLE: flush suppresses a same-cycle start.
- hi/lo read directly from the registers; the value is stable while busy (old value until FIX commits).
- Width rules:
  - Internal accumulators are 2·WIDTH bits.
  - Counter width is clog2(WIDTH+1).
  - All negation is two's complement modulo the respective width.

Decomposition:
- Shared package md_pkg holds:
  - md_op encodings MD_MULTU=2'b00, MD_MULT=2'b01, MD_DIVU=2'b10, MD_DIV=2'b11, identical to the decoder's MdOp field;
  - FSM state encodings ST_IDLE, ST_RUN, ST_FIX.
- One natural sub-module: md_iter_core, the combinational single-iteration datapath (one shift-add or one restore step). FSM and HI/LO registers stay in md_unit.

Test Plan:
- WIDTH=32, MULT src_a=FFFFFFFD, src_b=00000005 -> done at T+34: hi=FFFFFFFF, lo=FFFFFFF1; busy high exactly 33 cycles.
- MULTU FFFFFFFF × FFFFFFFF -> hi=FFFFFFFE, lo=00000001. Repeat with FAST_MUL=1 -> same result, done at T+3.
- DIV src_a=FFFFFFF9 (-7), src_b=2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIVU 7/0 -> lo=FFFFFFFF, hi=00000007.
- DIV MIN/-1: src_a=80000000, src_b=FFFFFFFF -> lo=80000000, hi=00000000.
- hi=lo=0 in IDLE, then:
  - hilo_write hilo_sel=1 src_a=12345678 -> hi=12345678 next cycle.
  - Start DIVU 100/7, then MTLO pulse and second start at T+5 -> both ignored.
  - Final result lo=0000000E, hi=00000002.
- Start MULT 6×7, flush at T+10 -> idle at T+11, no done, hi/lo unchanged. Reset asserted at T+5 of a new op -> all outputs 0 next cycle.
